// File: rtl/data_memory_responder.sv
// data_memory_responder: handshaked data memory with programmable wait states and held response.
module data_memory_responder #(
  parameter int n       = 64,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         request_valid,
  output logic         request_ready,
  input  logic         write,
  input  logic [n-1:0] input_address,
  input  logic [n-1:0] input_data,
  output logic         response_valid,
  input  logic         response_ready,
  output logic [n-1:0] output_data,
  output logic         output_error
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  logic [n-1:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, oerr_q, oerr_d;
  logic [n-1:0] addr_q, addr_d, data_q, data_d, odata_q, odata_d;
  logic accept, access, acc_wr, err;
  logic [n-1:0] acc_addr, acc_data;
  logic [AW-1:0] idx;
  always_comb begin
    request_ready = (state_q == IDLE) && reset;
    accept = request_valid && request_ready;
    // With zero wait states the access happens on the accept edge, so use live inputs in IDLE.
    acc_wr = (state_q == IDLE) ? write : wr_q;
    acc_addr = (state_q == IDLE) ? input_address : addr_q;
    acc_data = (state_q == IDLE) ? input_data : data_q;
    err = (|acc_addr[2:0]) || (acc_addr[n-1:3] >= (n-3)'(DEPTH));
    idx = acc_addr[AW+2:3];
    access = (state_q == IDLE) ? (accept && LATENCY == 0) : (state_q == WAIT && cnt_q == 4'd0);
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    odata_d = odata_q;
    oerr_d = oerr_q;
    if (accept) begin
      wr_d = write;
      addr_d = input_address;
      data_d = input_data;
      state_d = (LATENCY == 0) ? RESPOND : WAIT;
      cnt_d = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    end
    if (state_q == WAIT) cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    if (access) begin
      state_d = RESPOND;
      odata_d = (acc_wr || err) ? '0 : mem[idx];
      oerr_d = err;
    end
    if (state_q == RESPOND && response_ready) begin
      state_d = IDLE;
      odata_d = '0;
      oerr_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      odata_q <= '0;
      oerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      odata_q <= odata_d;
      oerr_q <= oerr_d;
    end
  end
  // Array is never reset; a low reset on the access edge suppresses the store.
  always_ff @(posedge clock) begin
    if (reset && access && acc_wr && !err) mem[idx] <= acc_data;
  end
  assign response_valid = (state_q == RESPOND);
  assign output_data = odata_q;
  assign output_error = oerr_q;
endmodule
